// File: rtl/led_anim_seq.sv
// ---------------------------------------------------------------------------
// led_anim_seq
//
// Self-timed LED / 7-segment animation sequencer. A host loads frame patterns
// into a small pattern RAM through a write port. The sequencer then steps a
// frame index through the window [start_frame, end_frame] at a rate set by an
// internal prescaler. It shows the pattern of the current frame on seg_o.
//
// Playback modes (mode input):
//    2'b00 loop       : start .. end, start .. end, ...
//    2'b01 ping-pong  : start .. end .. start .. end ...
//    2'b10 one-shot   : start .. end, then stop and raise done_o
//    2'b11 hold       : ticks keep pulsing, the frame index is frozen
//
// Parameters
//    SEG_W      segment bits per frame
//    FRAME_AW   frame address width, pattern RAM depth is 2**FRAME_AW
//    DIV_W      prescaler width
//    ACTIVE_LOW 1: blank pattern is all ones, 0: blank pattern is all zeros
//
// Ports
//    clk          system clock, rising edge
//    rst          asynchronous reset, active-high
//    en           run enable, low freezes prescaler and frame index
//    restart      reload start_frame, clear prescaler and done_o
//    mode         playback mode, see above
//    div          frame period in clocks minus one
//    start_frame  first frame of the window
//    end_frame    last frame of the window
//    wr_en        pattern RAM write strobe
//    wr_addr      pattern RAM write address
//    wr_data      pattern written to RAM
//    blink        (LED_ANIM_BLINK_EN builds only) blank 2nd half of each frame
//    seg_o        registered segment pattern
//    frame_o      current frame index
//    tick_o       one-cycle pulse on each frame advance
//    done_o       one-shot complete, sticky until restart or rst
//
// Build option
//    LED_ANIM_BLINK_EN : adds the blink input. While blink is high, seg_o is
//                        blanked when the prescaler is past half the period.
// ---------------------------------------------------------------------------
module led_anim_seq #(
   parameter int SEG_W      = 7,
   parameter int FRAME_AW   = 7,
   parameter int DIV_W      = 24,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                restart,
   input  logic [1:0]          mode,
   input  logic [DIV_W-1:0]    div,
   input  logic [FRAME_AW-1:0] start_frame,
   input  logic [FRAME_AW-1:0] end_frame,
   input  logic                wr_en,
   input  logic [FRAME_AW-1:0] wr_addr,
   input  logic [SEG_W-1:0]    wr_data,
`ifdef LED_ANIM_BLINK_EN
   input  logic                blink,
`endif
   output logic [SEG_W-1:0]    seg_o,
   output logic [FRAME_AW-1:0] frame_o,
   output logic                tick_o,
   output logic                done_o
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_RUN_FWD = 2'd1;
   localparam logic [1:0] ST_RUN_REV = 2'd2;
   localparam logic [1:0] ST_DONE    = 2'd3;

   localparam logic [1:0] MODE_LOOP    = 2'b00;
   localparam logic [1:0] MODE_PINGPONG = 2'b01;
   localparam logic [1:0] MODE_ONESHOT = 2'b10;
   localparam logic [1:0] MODE_HOLD    = 2'b11;

   localparam logic [SEG_W-1:0]    BLANK     = (ACTIVE_LOW != 0) ? {SEG_W{1'b1}} : {SEG_W{1'b0}};
   localparam logic [FRAME_AW-1:0] FRAME_ONE = {{(FRAME_AW-1){1'b0}}, 1'b1};
   localparam logic [DIV_W-1:0]    DIV_ONE   = {{(DIV_W-1){1'b0}}, 1'b1};
   localparam logic [DIV_W-1:0]    DIV_ZERO  = '0;

   localparam int RAM_DEPTH = 1 << FRAME_AW;

   logic [SEG_W-1:0]    ram_q [0:RAM_DEPTH-1];

   logic [1:0]          state_q, state_d;
   logic [FRAME_AW-1:0] frame_q, frame_d;
   logic [DIV_W-1:0]    presc_q, presc_d;
   logic                tick_q,  tick_d;
   logic                done_q,  done_d;
   logic [SEG_W-1:0]    seg_q,   seg_d;

   logic                running;
   logic                tick_c;
   logic                window_bad;
   logic [FRAME_AW-1:0] step_frame;
   logic [1:0]          step_state;
   logic                step_done;

   // Pattern RAM. It is not reset, so the host must load it before use.
   // The read side samples ram_q in the same clock edge as the write.
   // A read of the address being written therefore returns the old word.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         ram_q[wr_addr] <= wr_data;
      end
   end

   // Prescaler terminal count. The compare is ">=" rather than "==".
   // If div is lowered mid-frame below the current count, the count still
   // terminates on the next cycle instead of wrapping through the full range.
   always_comb begin
      running    = (state_q == ST_RUN_FWD) || (state_q == ST_RUN_REV);
      tick_c     = running && en && (presc_q >= div);
      window_bad = (end_frame < start_frame);
   end

   // Frame step taken one cycle after a tick.
   // It uses the mode and window present at that moment, so mid-run changes
   // take effect at the next frame advance.
   // An inverted window pins the index to start_frame.
   // An index left outside a changed window is pulled back to start_frame.
   // This keeps the index inside [start,end] at all times.
   always_comb begin
      step_frame = frame_q;
      step_state = state_q;
      step_done  = 1'b0;
      if (window_bad) begin
         step_frame = start_frame;
      end else if (mode == MODE_HOLD) begin
         step_frame = frame_q;
      end else if ((frame_q < start_frame) || (frame_q > end_frame)) begin
         step_frame = start_frame;
         step_state = ST_RUN_FWD;
      end else if (state_q == ST_RUN_REV) begin
         if (frame_q > start_frame) begin
            step_frame = frame_q - FRAME_ONE;
         end else if (start_frame != end_frame) begin
            step_frame = frame_q + FRAME_ONE;
            step_state = ST_RUN_FWD;
         end else begin
            step_state = ST_RUN_FWD;
         end
      end else begin
         if (frame_q < end_frame) begin
            step_frame = frame_q + FRAME_ONE;
         end else begin
            case (mode)
               MODE_LOOP: begin
                  step_frame = start_frame;
               end
               MODE_PINGPONG: begin
                  // A single-frame window has nowhere to bounce to, so
                  // the frame is held and direction stays forward.
                  if (start_frame != end_frame) begin
                     step_frame = frame_q - FRAME_ONE;
                     step_state = ST_RUN_REV;
                  end
               end
               MODE_ONESHOT: begin
                  step_state = ST_DONE;
                  step_done  = 1'b1;
               end
               default: begin
                  step_frame = frame_q;
               end
            endcase
         end
      end
   end

   // Main next-state logic. restart overrides everything else, including a
   // pending tick. tick_o is registered from the terminal count, and the frame
   // index steps on the following edge, one cycle behind the tick.
   always_comb begin
      state_d = state_q;
      frame_d = frame_q;
      presc_d = presc_q;
      tick_d  = 1'b0;
      done_d  = done_q;
      if (restart) begin
         state_d = ST_RUN_FWD;
         frame_d = start_frame;
         presc_d = DIV_ZERO;
         done_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (en) begin
                  state_d = ST_RUN_FWD;
                  frame_d = start_frame;
               end
            end
            ST_RUN_FWD, ST_RUN_REV: begin
               if (en) begin
                  presc_d = tick_c ? DIV_ZERO : (presc_q + DIV_ONE);
                  tick_d  = tick_c;
               end
               if (tick_q) begin
                  frame_d = step_frame;
                  state_d = step_state;
                  if (step_done) begin
                     done_d  = 1'b1;
                     presc_d = DIV_ZERO;
                  end
               end
            end
            default: begin
               state_d = ST_DONE;
            end
         endcase
      end
   end

   // Segment output register. It reads the RAM at the current frame index,
   // so seg_o trails frame_o by one clock.
   // IDLE keeps the blank reset value, so an unloaded RAM is never displayed.
   // In DONE the frame is frozen, so seg_o holds unless the host rewrites
   // that frame.
   always_comb begin
      seg_d = seg_q;
      if (state_q != ST_IDLE) begin
         seg_d = ram_q[frame_q];
      end
`ifdef LED_ANIM_BLINK_EN
      if (blink && running && (presc_q > (div >> 1))) begin
         seg_d = BLANK;
      end
`endif
   end

   // State registers, all cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         frame_q <= '0;
         presc_q <= '0;
         tick_q  <= 1'b0;
         done_q  <= 1'b0;
         seg_q   <= BLANK;
      end else begin
         state_q <= state_d;
         frame_q <= frame_d;
         presc_q <= presc_d;
         tick_q  <= tick_d;
         done_q  <= done_d;
         seg_q   <= seg_d;
      end
   end

   assign seg_o   = seg_q;
   assign frame_o = frame_q;
   assign tick_o  = tick_q;
   assign done_o  = done_q;

endmodule

// File: tb/tb_led_anim_seq.sv
// ---------------------------------------------------------------------------
// tb_led_anim_seq
//
// Directed testbench for led_anim_seq with default parameters
// (SEG_W=7, FRAME_AW=7, DIV_W=24, ACTIVE_LOW=1).
// Expected values are hand-derived frame sequences and timing.
// ---------------------------------------------------------------------------
module tb_led_anim_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        restart;
   logic [1:0]  mode;
   logic [23:0] div;
   logic [6:0]  start_frame;
   logic [6:0]  end_frame;
   logic        wr_en;
   logic [6:0]  wr_addr;
   logic [6:0]  wr_data;
`ifdef LED_ANIM_BLINK_EN
   logic        blink = 1'b0;
`endif
   logic [6:0]  seg_o;
   logic [6:0]  frame_o;
   logic        tick_o;
   logic        done_o;

   int num_checks = 0;
   int num_errors = 0;

   int loop_seq [5] = '{2, 3, 4, 5, 2};
   int pp_seq   [8] = '{0, 1, 2, 3, 2, 1, 0, 1};

   led_anim_seq dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .restart     (restart),
      .mode        (mode),
      .div         (div),
      .start_frame (start_frame),
      .end_frame   (end_frame),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
`ifdef LED_ANIM_BLINK_EN
      .blink       (blink),
`endif
      .seg_o       (seg_o),
      .frame_o     (frame_o),
      .tick_o      (tick_o),
      .done_o      (done_o)
   );

   // 10-unit clock period.
   always #5 clk = ~clk;

   // Compare one observed value against its expected value.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      num_checks++;
      if (actual !== expected) begin
         num_errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Advance n clock edges, then settle 1 unit past the last edge.
   task automatic waitCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Load a playback configuration and pulse restart for one edge.
   task automatic applyStimulus(input logic [1:0] m, input logic [23:0] d,
                                input logic [6:0] s, input logic [6:0] e);
      mode        = m;
      div         = d;
      start_frame = s;
      end_frame   = e;
      restart     = 1'b1;
      waitCycles(1);
      restart     = 1'b0;
   endtask

   // Guard against a hung run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst         = 1'b1;
      en          = 1'b0;
      restart     = 1'b0;
      mode        = 2'b00;
      div         = '0;
      start_frame = '0;
      end_frame   = '0;
      wr_en       = 1'b0;
      wr_addr     = '0;
      wr_data     = '0;

      waitCycles(3);
      checkOutput("reset_seg", seg_o, 32'h7F);
      checkOutput("reset_frame", frame_o, 0);
      checkOutput("reset_tick", tick_o, 0);
      checkOutput("reset_done", done_o, 0);
      rst = 1'b0;

      // Load RAM[i] = i while the sequencer idles with en low.
      for (int i = 0; i < 128; i++) begin
         wr_en   = 1'b1;
         wr_addr = 7'(i);
         wr_data = 7'(i);
         waitCycles(1);
      end
      wr_en = 1'b0;
      checkOutput("idle_seg_blank", seg_o, 32'h7F);
      checkOutput("idle_frame", frame_o, 0);

      // Loop: window 2..5, div=3, tick every 4 clocks.
      en = 1'b1;
      applyStimulus(2'b00, 24'd3, 7'd2, 7'd5);
      checkOutput("loop_start", frame_o, 2);
      for (int k = 0; k < 5; k++) begin
         waitCycles(1);
         checkOutput("loop_frame", frame_o, loop_seq[k]);
         checkOutput("loop_seg_trail", seg_o, (k > 0) ? loop_seq[k-1] : loop_seq[0]);
         waitCycles(1);
         checkOutput("loop_seg", seg_o, loop_seq[k]);
         waitCycles(1);
         checkOutput("loop_no_tick", tick_o, 0);
         waitCycles(1);
         checkOutput("loop_tick", tick_o, 1);
         checkOutput("loop_frame_at_tick", frame_o, loop_seq[k]);
      end

      // Ping-pong: window 0..3, div=0, tick every clock.
      applyStimulus(2'b01, 24'd0, 7'd0, 7'd3);
      for (int k = 0; k < 8; k++) begin
         waitCycles(1);
         checkOutput("pp_frame", frame_o, pp_seq[k]);
         checkOutput("pp_tick", tick_o, 1);
      end

      // One-shot: window 10..12, div=1.
      applyStimulus(2'b10, 24'd1, 7'd10, 7'd12);
      checkOutput("os_start", frame_o, 10);
      waitCycles(2);
      checkOutput("os_tick", tick_o, 1);
      checkOutput("os_frame_at_tick", frame_o, 10);
      waitCycles(1);
      checkOutput("os_frame11", frame_o, 11);
      waitCycles(2);
      checkOutput("os_frame12", frame_o, 12);
      checkOutput("os_not_done", done_o, 0);
      waitCycles(2);
      checkOutput("os_done", done_o, 1);
      checkOutput("os_done_frame", frame_o, 12);
      waitCycles(5);
      checkOutput("os_done_held", done_o, 1);
      checkOutput("os_frame_held", frame_o, 12);
      checkOutput("os_no_tick", tick_o, 0);
      checkOutput("os_seg_held", seg_o, 12);
      applyStimulus(2'b10, 24'd1, 7'd10, 7'd12);
      checkOutput("os_restart_frame", frame_o, 10);
      checkOutput("os_restart_done", done_o, 0);
      waitCycles(7);
      checkOutput("os_done_again", done_o, 1);

      // Asynchronous reset in the middle of a clock period.
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async_rst_seg", seg_o, 32'h7F);
      checkOutput("async_rst_frame", frame_o, 0);
      checkOutput("async_rst_done", done_o, 0);
      checkOutput("async_rst_tick", tick_o, 0);
      waitCycles(2);
      rst = 1'b0;
      en  = 1'b1;

      // Inverted window: start=5, end=3 pins the frame; done never sets.
      applyStimulus(2'b10, 24'd0, 7'd5, 7'd3);
      checkOutput("inv_start", frame_o, 5);
      for (int k = 0; k < 6; k++) begin
         waitCycles(1);
         checkOutput("inv_frame", frame_o, 5);
         checkOutput("inv_done", done_o, 0);
      end
      checkOutput("inv_seg", seg_o, 5);

      // Write to the current frame: old data for one cycle, new data next.
      wr_en   = 1'b1;
      wr_addr = 7'd5;
      wr_data = 7'h36;
      waitCycles(1);
      wr_en = 1'b0;
      checkOutput("wr_old_data", seg_o, 5);
      waitCycles(1);
      checkOutput("wr_new_data", seg_o, 32'h36);

      // Restart on the same cycle as a tick: restart wins.
      applyStimulus(2'b00, 24'd0, 7'd0, 7'd3);
      waitCycles(3);
      checkOutput("rt_pre_tick", tick_o, 1);
      checkOutput("rt_pre_frame", frame_o, 2);
      applyStimulus(2'b00, 24'd0, 7'd0, 7'd3);
      checkOutput("rt_frame", frame_o, 0);
      checkOutput("rt_tick", tick_o, 0);
      waitCycles(1);
      checkOutput("rt_after_frame", frame_o, 0);

      // Hold mode: ticks pulse, frame does not move.
      applyStimulus(2'b11, 24'd0, 7'd0, 7'd3);
      waitCycles(4);
      checkOutput("hold_frame", frame_o, 0);
      checkOutput("hold_tick", tick_o, 1);

      $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
      $finish;
   end

endmodule
